// File: rtl/pixel_collector_if.sv
// Engine-batch in / pixel-stream out bundle for the pixel collector.
// Pure wiring, no latency.
// res_valid/res_ready and out_valid/out_ready are independent valid/ready pairs.
interface pixel_collector_if #(
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int RESULT_WIDTH     = 8,
    parameter int NUM_ENGINES      = 8
);
    logic                                res_valid;
    logic [NUM_ENGINES*RESULT_WIDTH-1:0] res_data;
    logic                                res_ready;
    logic                                fin_flag;
    logic [RESULT_WIDTH-1:0]             out_data;
    logic [PIXEL_DATA_WIDTH-1:0]         out_x;
    logic [PIXEL_DATA_WIDTH-1:0]         out_y;
    logic                                out_sof;
    logic                                out_eol;
    logic                                out_valid;
    logic                                out_ready;

    // Collector side: receives engine batches, sources the pixel stream.
    modport slave (
        input  res_valid, res_data, out_ready,
        output res_ready, fin_flag, out_data, out_x, out_y, out_sof, out_eol, out_valid
    );

    // Environment side: engines drive batches, frame writer drives out_ready.
    modport master (
        output res_valid, res_data, out_ready,
        input  res_ready, fin_flag, out_data, out_x, out_y, out_sof, out_eol, out_valid
    );
endinterface

// File: rtl/pixel_collector.sv
// Buffers one NUM_ENGINES-wide result batch and serialises it one pixel per cycle with raster x/y.
// Latency: first pixel one cycle after batch accept; back-to-back batches stream with no bubble.
// Backpressure: out_ready low freezes all out_* fields and holds res_ready low.
module pixel_collector #(
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int RESULT_WIDTH     = 8,
    parameter int SCREEN_WIDTH     = 640,
    parameter int SCREEN_HEIGHT    = 480,
    parameter int NUM_ENGINES      = 8
) (
    input  logic             clk,
    input  logic             reset,
    pixel_collector_if.slave bus
);
    localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [IDX_W-1:0]            LAST_IDX = IDX_W'(NUM_ENGINES - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST   = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST   = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]                                 state_q, state_d;
    logic [IDX_W-1:0]                           idx_q, idx_d;
    logic [PIXEL_DATA_WIDTH-1:0]                x_q, x_d;
    logic [PIXEL_DATA_WIDTH-1:0]                y_q, y_d;
    logic [NUM_ENGINES-1:0][RESULT_WIDTH-1:0]   buf_q, buf_d;

    logic out_valid;
    logic xfer;
    logic last_pix;
    logic res_ready;
    logic accept;

    // Handshake decode: a new batch fits only when empty or when the last pixel leaves this cycle.
    always_comb begin
        out_valid = (state_q == ST_DRAIN);
        xfer      = out_valid && bus.out_ready;
        last_pix  = (idx_q == LAST_IDX);
        res_ready = !reset && ((state_q == ST_EMPTY) || (xfer && last_pix));
        accept    = bus.res_valid && res_ready;
    end

    // Next state: pixel transfer advances idx and raster; accept reloads the buffer and wins over EMPTY.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        buf_d   = buf_q;
        if (xfer) begin
            if (last_pix) begin
                state_d = ST_EMPTY;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + PIXEL_DATA_WIDTH'(1);
            end else begin
                x_d = x_q + PIXEL_DATA_WIDTH'(1);
            end
        end
        if (accept) begin
            buf_d   = bus.res_data;
            idx_d   = '0;
            state_d = ST_DRAIN;
        end
    end

    // State registers; reset drops any buffered batch and rewinds the raster to the frame origin.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.res_ready = res_ready;
    assign bus.fin_flag  = accept;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = buf_q[idx_q];
    assign bus.out_x     = x_q;
    assign bus.out_y     = y_q;
    assign bus.out_sof   = (x_q == '0) && (y_q == '0);
    assign bus.out_eol   = (x_q == X_LAST);
endmodule
